// File: rtl/noc_packet_tx.sv
// NoC packet transmitter: turns a request plus its payload stream into header + payload
// flits on a registered valid/ready output stage feeding the router input buffer.
module noc_packet_tx #(
  parameter int FLIT_WIDTH = 32,
  parameter int MAX_LEN    = 8,
  parameter int SRC_ID     = 0,
  localparam int LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_dest,
  input  logic [2:0]            req_class,
  input  logic [LW-1:0]         req_len,
  input  logic [FLIT_WIDTH-1:0] pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  len_err,
  input  logic                  err_clr,
  output logic [15:0]           tx_packets,
  output logic                  busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE_L     = LW'(1);
  localparam logic [4:0]    SRC_ID_L  = 5'(SRC_ID);

  logic [0:0]    state;
  logic [LW-1:0] remaining;
  logic          ld;
  logic          req_fire;
  logic          pl_fire;
  logic          len_ok;

  function automatic logic [FLIT_WIDTH-1:0] build_header(
    input logic [4:0]    dest,
    input logic [2:0]    cls,
    input logic [LW-1:0] len
  );
    logic [FLIT_WIDTH-1:0] h;
    h = '0;
    h[FLIT_WIDTH-1 -: 5] = dest;
    h[FLIT_WIDTH-6 -: 3] = cls;
    h[FLIT_WIDTH-9 -: 5] = SRC_ID_L;
    h[LW-1:0]            = len;
    return h;
  endfunction

  // Output stage may load whenever it is empty or being drained this cycle.
  always_comb begin
    ld        = ~out_valid | out_ready;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    case (state)
      IDLE:    req_ready = ld;
      PAYLOAD: pl_ready  = ld;
      default: begin
        req_ready = 1'b0;
        pl_ready  = 1'b0;
      end
    endcase
    req_fire = req_valid & req_ready;
    pl_fire  = pl_valid & pl_ready;
    len_ok   = (req_len <= MAX_LEN_L);
    busy     = (state == PAYLOAD) | out_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ld) begin
      case (state)
        IDLE: begin
          if (req_fire && len_ok) begin
            out_flit  <= build_header(req_dest, req_class, req_len);
            out_last  <= (req_len == '0);
            out_valid <= 1'b1;
            remaining <= req_len;
            state     <= (req_len != '0) ? PAYLOAD : IDLE;
          end else begin
            // Oversized requests are consumed without producing a flit.
            out_valid <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (pl_fire) begin
            out_flit  <= pl_data;
            out_last  <= (remaining == ONE_L);
            out_valid <= 1'b1;
            remaining <= remaining - ONE_L;
            if (remaining == ONE_L) begin
              state <= IDLE;
            end else begin
              state <= PAYLOAD;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end else begin
      out_valid <= out_valid;
    end
  end

  // Sticky length error; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err <= 1'b0;
    end else if (req_fire && !len_ok) begin
      len_err <= 1'b1;
    end else if (err_clr) begin
      len_err <= 1'b0;
    end else begin
      len_err <= len_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_packets <= 16'd0;
    end else if (out_valid && out_ready && out_last) begin
      tx_packets <= tx_packets + 16'd1;
    end else begin
      tx_packets <= tx_packets;
    end
  end

endmodule

// File: tb/tb_noc_packet_tx.sv
// Self-checking bench for noc_packet_tx: a queue-based packet model predicts every
// output beat, and a negedge monitor records what the block actually emitted.
module tb_noc_packet_tx;

  localparam int FW      = 32;
  localparam int MAX_LEN = 8;
  localparam int SRC_ID  = 5;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_dest;
  logic [2:0]    req_class;
  logic [LW-1:0] req_len;
  logic [FW-1:0] pl_data;
  logic          pl_valid;
  logic          pl_ready;
  logic [FW-1:0] out_flit;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          len_err;
  logic          err_clr;
  logic [15:0]   tx_packets;
  logic          busy;

  typedef struct {
    logic [FW-1:0] flit;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  int  cmp_cnt = 0;
  int  err_cnt = 0;
  int  pkts_exp = 0;
  int  cyc = 0;
  int  stab_err = 0;
  int  pl_ready_cnt = 0;
  bit  rnd_ready = 1'b0;

  noc_packet_tx #(.FLIT_WIDTH(FW), .MAX_LEN(MAX_LEN), .SRC_ID(SRC_ID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_class(req_class), .req_len(req_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .len_err(len_err), .err_clr(err_clr),
    .tx_packets(tx_packets), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: record accepted beats and watch for changes while stalled.
  initial begin
    logic          prev_stall;
    logic [FW-1:0] prev_flit;
    logic          prev_last;
    prev_stall = 1'b0;
    prev_flit  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (pl_ready) pl_ready_cnt++;
        if (prev_stall && (!out_valid || out_flit !== prev_flit || out_last !== prev_last))
          stab_err++;
        if (out_valid && out_ready) obs_q.push_back('{flit: out_flit, last: out_last, cyc: cyc});
        prev_stall = out_valid && !out_ready;
        prev_flit  = out_flit;
        prev_last  = out_last;
      end
    end
  end

  function automatic logic [FW-1:0] hdr_model(input int d, input int c, input int len);
    return (FW'(d) << (FW - 5)) | (FW'(c) << (FW - 8)) | (FW'(SRC_ID) << (FW - 13)) | FW'(len);
  endfunction

  // Issue one request and feed its payload; starts and ends just after a rising edge.
  task automatic send_packet(input int d, input int c, input int len, input bit rnd_pl,
                             input bit fixed, input logic [FW-1:0] base);
    int sent;
    int guard;
    bit done;
    req_valid = 1'b1;
    req_dest  = 5'(d);
    req_class = 3'(c);
    req_len   = LW'(len);
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 2000) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL req_timeout: req_ready=%0b required 1", req_ready);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (len <= MAX_LEN) begin
      exp_q.push_back('{flit: hdr_model(d, c, len), last: (len == 0), cyc: 0});
      pkts_exp++;
      sent  = 0;
      guard = 0;
      while (sent < len && guard <= 4000) begin
        pl_valid = rnd_pl ? ($urandom_range(0, 3) != 0) : 1'b1;
        pl_data  = fixed ? base + FW'(sent) : FW'($urandom);
        @(negedge clk);
        if (pl_valid && pl_ready) begin
          exp_q.push_back('{flit: pl_data, last: (sent == len - 1), cyc: 0});
          sent++;
        end
        guard++;
        @(posedge clk);
        #1;
      end
      pl_valid = 1'b0;
      if (sent < len) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL pl_timeout: sent=%0d required %0d", sent, len);
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    if (obs_q.size() != exp_q.size()) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL drain: beats=%0d required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_dest = '0; req_class = '0; req_len = '0;
    pl_data = '0; pl_valid = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++; if (out_valid !== 1'b0)   begin err_cnt++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    cmp_cnt++; if (out_last !== 1'b0)    begin err_cnt++; $display("FAIL rst_out_last: got %0b required 0", out_last); end
    cmp_cnt++; if (out_flit !== '0)      begin err_cnt++; $display("FAIL rst_out_flit: got %h required 0", out_flit); end
    cmp_cnt++; if (len_err !== 1'b0)     begin err_cnt++; $display("FAIL rst_len_err: got %0b required 0", len_err); end
    cmp_cnt++; if (busy !== 1'b0)        begin err_cnt++; $display("FAIL rst_busy: got %0b required 0", busy); end
    cmp_cnt++; if (tx_packets !== 16'd0) begin err_cnt++; $display("FAIL rst_tx_packets: got %0d required 0", tx_packets); end
    cmp_cnt++; if (req_ready !== 1'b1)   begin err_cnt++; $display("FAIL rst_req_ready: got %0b required 1", req_ready); end
    cmp_cnt++; if (pl_ready !== 1'b0)    begin err_cnt++; $display("FAIL rst_pl_ready: got %0b required 0", pl_ready); end
    rst = 1'b0;
    pkts_exp = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [FW-1:0] exp_flit [3];
    logic          exp_last [3];
    exp_flit[0] = 32'h1900_0000 | (32'(SRC_ID) << 19) | 32'd2;
    exp_flit[1] = 32'h0000_000A;
    exp_flit[2] = 32'h0000_000B;
    exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b1;
    send_packet(3, 1, 2, 1'b0, 1'b1, 32'h0000_000A);
    drain();
    cmp_cnt++;
    if (obs_q.size() != 3) begin
      err_cnt++;
      $display("FAIL basic_beats: got %0d required 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        cmp_cnt++;
        if (obs_q[i].flit !== exp_flit[i] || obs_q[i].last !== exp_last[i]) begin
          err_cnt++;
          $display("FAIL basic_beat%0d: got %h/%0b required %h/%0b", i, obs_q[i].flit, obs_q[i].last,
                   exp_flit[i], exp_last[i]);
        end
      end
    end
    cmp_cnt++;
    if (tx_packets !== 16'd1) begin err_cnt++; $display("FAIL basic_tx_packets: got %0d required 1", tx_packets); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zero_len();
    int pr0;
    int d;
    int c;
    pr0 = pl_ready_cnt;
    d = $urandom_range(0, 31);
    c = $urandom_range(0, 7);
    send_packet(d, c, 0, 1'b0, 1'b0, '0);
    drain();
    cmp_cnt++;
    if (obs_q.size() != 1) begin
      err_cnt++;
      $display("FAIL zero_beats: got %0d required 1", obs_q.size());
    end else begin
      cmp_cnt++;
      if (obs_q[0].flit !== hdr_model(d, c, 0) || obs_q[0].last !== 1'b1) begin
        err_cnt++;
        $display("FAIL zero_header: got %h/%0b required %h/1", obs_q[0].flit, obs_q[0].last, hdr_model(d, c, 0));
      end
    end
    cmp_cnt++;
    if (pl_ready_cnt != pr0) begin err_cnt++; $display("FAIL zero_pl_ready: got %0d cycles required 0", pl_ready_cnt - pr0); end
    cmp_cnt++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL zero_idle: busy=%0b req_ready=%0b required 0/1", busy, req_ready);
    end
    cmp_cnt++;
    if (tx_packets !== 16'(pkts_exp)) begin err_cnt++; $display("FAIL zero_tx_packets: got %0d required %0d", tx_packets, pkts_exp); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_len_err();
    req_valid = 1'b1; req_dest = 5'd7; req_class = 3'd2; req_len = LW'(MAX_LEN + 1);
    err_clr = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL lenerr_req_ready: got %0b required 1", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 1'b0; err_clr = 1'b0;
    cmp_cnt++;
    if (len_err !== 1'b1) begin err_cnt++; $display("FAIL lenerr_set: got %0b required 1", len_err); end
    cmp_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL lenerr_no_flit: out_valid=%0b required 0", out_valid); end
    @(posedge clk);
    #1;
    cmp_cnt++;
    if (len_err !== 1'b1) begin err_cnt++; $display("FAIL lenerr_sticky: got %0b required 1", len_err); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    cmp_cnt++;
    if (len_err !== 1'b0) begin err_cnt++; $display("FAIL lenerr_clear: got %0b required 0", len_err); end
    cmp_cnt++;
    if (obs_q.size() != 0) begin err_cnt++; $display("FAIL lenerr_beats: got %0d required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pkts_exp;
    send_packet(1, 4, MAX_LEN, 1'b0, 1'b0, '0);
    send_packet(30, 6, MAX_LEN, 1'b0, 1'b0, '0);
    drain();
    cmp_cnt++;
    if (obs_q.size() != 2 * (MAX_LEN + 1)) begin
      err_cnt++;
      $display("FAIL b2b_beats: got %0d required %0d", obs_q.size(), 2 * (MAX_LEN + 1));
    end else begin
      for (int i = 0; i < 2 * (MAX_LEN + 1); i++) begin
        cmp_cnt++;
        if (obs_q[i].flit !== exp_q[i].flit || obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != obs_q[0].cyc + i) begin
          err_cnt++;
          $display("FAIL b2b_beat%0d: got %h/%0b@%0d required %h/%0b@%0d", i, obs_q[i].flit, obs_q[i].last,
                   obs_q[i].cyc, exp_q[i].flit, exp_q[i].last, obs_q[0].cyc + i);
        end
      end
    end
    cmp_cnt++;
    if (tx_packets !== 16'(pkts_exp) || pkts_exp - p0 != 2) begin
      err_cnt++; $display("FAIL b2b_tx_packets: got %0d required %0d", tx_packets, pkts_exp);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    stab_err = 0;
    rnd_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      send_packet($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, MAX_LEN), 1'b1, 1'b0, '0);
    end
    drain();
    rnd_ready = 1'b0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      cmp_cnt++;
      if (obs_q[i].flit !== exp_q[i].flit || obs_q[i].last !== exp_q[i].last) begin
        err_cnt++;
        if (bad < 10)
          $display("FAIL rand_beat%0d: got %h/%0b required %h/%0b", i, obs_q[i].flit, obs_q[i].last,
                   exp_q[i].flit, exp_q[i].last);
        bad++;
      end
    end
    cmp_cnt++;
    if (stab_err != 0) begin err_cnt++; $display("FAIL rand_stall_stable: got %0d changes required 0", stab_err); end
    cmp_cnt++;
    if (tx_packets !== 16'(pkts_exp)) begin err_cnt++; $display("FAIL rand_tx_packets: got %0d required %0d", tx_packets, pkts_exp); end
    exp_q.delete(); obs_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_dest = 5'd9; req_class = 3'd3; req_len = LW'(4);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pl_valid = 1'b1; pl_data = 32'hDEAD_0001;
    @(posedge clk);
    #1;
    pl_valid = 1'b0;
    cmp_cnt++;
    if (out_valid !== 1'b1 || out_flit !== 32'hDEAD_0001) begin
      err_cnt++; $display("FAIL mid_payload: got %0b/%h required 1/dead0001", out_valid, out_flit);
    end
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_out_valid: got %0b required 0", out_valid); end
    cmp_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_busy: got %0b required 0", busy); end
    cmp_cnt++;
    if (pl_ready !== 1'b0 || req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL mid_ready: pl_ready=%0b req_ready=%0b required 0/1", pl_ready, req_ready);
    end
    exp_q.delete(); obs_q.delete();
    pkts_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_packet(12, 5, 3, 1'b0, 1'b1, 32'h0000_0100);
    drain();
    cmp_cnt++;
    if (obs_q.size() != 4) begin
      err_cnt++; $display("FAIL mid_fresh_beats: got %0d required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        cmp_cnt++;
        if (obs_q[i].flit !== exp_q[i].flit || obs_q[i].last !== exp_q[i].last) begin
          err_cnt++;
          $display("FAIL mid_fresh_beat%0d: got %h/%0b required %h/%0b", i, obs_q[i].flit, obs_q[i].last,
                   exp_q[i].flit, exp_q[i].last);
        end
      end
    end
    cmp_cnt++;
    if (tx_packets !== 16'd1) begin err_cnt++; $display("FAIL mid_tx_packets: got %0d required 1", tx_packets); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_len_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/noc_packet_tx.md
# noc_packet_tx

Packet transmitter that builds NoC packets from a local request/payload interface and drives the input side of a NoC FIFO buffer (flit, last, valid, ready). Each accepted request emits one header flit followed by exactly `req_len` payload flits, with `last` marking the final flit. The block sits between a tile-local producer (DMA, message-passing unit) and the buffer feeding the router. Its output is a registered stage, so back-to-back packets stream without bubbles.

## Interface

Parameters:

- `FLIT_WIDTH`, 32: flit width; must be at least 13 + LW.
- `MAX_LEN`, 8: maximum payload flits per packet.
- `SRC_ID`, 0: 5-bit source tile id placed in every header.
- `LW` (localparam), `$clog2(MAX_LEN+1)`: width of the length field.

Ports:

- `clk`  in  1: single clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `req_valid`  in  1: packet request valid.
- `req_ready`  out  1: request accepted when `req_valid & req_ready`.
- `req_dest`  in  5: destination tile.
- `req_class`  in  3: message class.
- `req_len`  in  LW: payload flit count, 0..MAX_LEN.
- `pl_data`  in  FLIT_WIDTH: payload flit.
- `pl_valid`  in  1: payload valid.
- `pl_ready`  out  1: payload accepted when `pl_valid & pl_ready`.
- `out_flit`  out  FLIT_WIDTH: registered flit to the buffer.
- `out_last`  out  1: registered last-flit marker.
- `out_valid`  out  1: registered valid.
- `out_ready`  in  1: buffer ready.
- `len_err`  out  1: sticky flag, set when a request with `req_len > MAX_LEN` is accepted.
- `err_clr`  in  1: clears `len_err`.
- `tx_packets`  out  16: count of completed packets; wraps.
- `busy`  out  1: high in PAYLOAD or while `out_valid`.

## Operation

- Header flit layout:
  - `[FW-1 -: 5]` = `req_dest`
  - `[FW-6 -: 3]` = `req_class`
  - `[FW-9 -: 5]` = `SRC_ID`
  - `[LW-1:0]` = `req_len`
  - all other bits 0
- Output register load enable: `ld = ~out_valid | out_ready`. The register holds its value while `out_valid & ~out_ready`.
- FSM states are IDLE and PAYLOAD; `remaining` is an LW-bit counter.
- IDLE:
  - `req_ready = ld`; `pl_ready = 0`.
  - On a request handshake with `req_len <= MAX_LEN`: load the header, set `out_last = (req_len == 0)`, set `remaining = req_len`. Go to PAYLOAD if `req_len != 0`, else stay in IDLE.
  - On a request handshake with `req_len > MAX_LEN`: emit no flit, set `len_err`, stay in IDLE.
  - If `ld` is true and no flit is loaded, `out_valid` goes to 0.
- PAYLOAD:
  - `req_ready = 0`; `pl_ready = ld` (combinational path from `out_ready`).
  - On a payload handshake: load `pl_data`, set `out_last = (remaining == 1)`, decrement `remaining`. Return to IDLE when `remaining == 1`.
  - If `ld` is true and there is no payload handshake, `out_valid` goes to 0 (bubble).
- `tx_packets` increments on `out_valid & out_ready & out_last`.
- `len_err`: a set and `err_clr` in the same cycle leaves it set. Otherwise `err_clr` clears it.
- Reset mid-packet: all state is cleared immediately and the partial packet is abandoned. The downstream buffer must be reset together with this block.

## Timing

- Reset values:
  - `out_valid`, `out_last`, `len_err`, `busy` = 0
  - `out_flit` = 0; `tx_packets` = 0
  - state = IDLE; `remaining` = 0
  - `req_ready` = 1; `pl_ready` = 0
- Latency: the header appears on `out_*` in the cycle after the request handshake. Each payload flit appears in the cycle after its handshake.
- Throughput: one flit per cycle when `out_ready` is held at 1. The next request's header follows the previous last flit with no idle cycle.
- A packet of N payload flits occupies N+1 output beats. `out_last` is asserted on exactly one beat per packet.
- The block never drops or reorders flits under arbitrary `out_ready` stalls. `out_flit`/`out_last` are stable while `out_valid & ~out_ready`.

## Test plan

- Reset, then request dest=3, class=1, len=2, payload 0xA, 0xB, `out_ready`=1 -> beats are header (dest 3, class 1, len 2), 0xA, 0xB. Only 0xB has last. `tx_packets` = 1.
- Request with len=0 -> exactly one header beat with `out_last` = 1. State stays IDLE; `pl_ready` is never asserted.
- Request with len=MAX_LEN+1 -> no `out_valid`, `len_err` = 1. A simultaneous `err_clr` keeps it at 1; `err_clr` the next cycle clears it.
- Two back-to-back len=MAX_LEN requests with `out_ready`=1 -> 2*(MAX_LEN+1) consecutive valid beats with no gap. `tx_packets` = 2.
- Random `out_ready` toggling (50%) and random `pl_valid` over 1000 packets -> scoreboard matches all flits. `out_flit` is stable during stalls.
- Assert `rst` after the header plus one payload beat of a len=4 packet -> `out_valid` = 0 and `busy` = 0 immediately. A new request after release produces a correct fresh packet.
